// File: rtl/altera_up_ps2_command_out_pkg.sv
// Shared definitions for the PS/2 controller: transmitter state encoding,
// default timing constants for a 50 MHz system clock, and a parity helper.
package altera_up_ps2_command_out_pkg;

    // Host-to-device transmitter states. All eight 3-bit codes are used.
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_INIT     = 3'd1,
        S_WAIT_CLK = 3'd2,
        S_TX_DATA  = 3'd3,
        S_TX_STOP  = 3'd4,
        S_RX_ACK   = 3'd5,
        S_SENT     = 3'd6,
        S_ERROR    = 3'd7
    } ps2_tx_state_t;

    // Default cycle counts at 50 MHz.
    localparam int unsigned DEFAULT_CYCLES_101US = 5050;
    localparam int unsigned DEFAULT_CYCLES_15MS  = 750000;
    localparam int unsigned DEFAULT_CYCLES_2MS   = 100000;

    // Index of the parity bit inside the transmitted frame.
    localparam logic [3:0] PARITY_BIT_INDEX = 4'd8;

    // Parity bit that makes the nine-bit frame contain an odd number of ones.
    function automatic logic odd_parity_bit(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/altera_up_ps2_command_out.sv
// PS/2 host-to-device transmitter: inhibits the bus clock, presents a start
// bit, shifts out eight data bits plus odd parity on device clock edges,
// releases the line for the stop bit and waits for the device acknowledge.
// Reports success or a timeout through sticky status flags that clear once
// the request is withdrawn.
module altera_up_ps2_command_out
    import altera_up_ps2_command_out_pkg::*;
#(
    parameter int unsigned CLOCK_CYCLES_FOR_101US = DEFAULT_CYCLES_101US,
    parameter int unsigned CLOCK_CYCLES_FOR_15MS  = DEFAULT_CYCLES_15MS,
    parameter int unsigned CLOCK_CYCLES_FOR_2MS   = DEFAULT_CYCLES_2MS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] the_command,
    input  logic       send_command,
    input  logic       ps2_clk_posedge,
    input  logic       ps2_clk_negedge,
    inout  logic       PS2_CLK,
    inout  logic       PS2_DAT,
    output logic       command_was_sent,
    output logic       error_communication_timed_out
);

    localparam int unsigned INIT_W = $clog2(CLOCK_CYCLES_FOR_101US + 1);
    localparam int unsigned WAIT_W = $clog2(CLOCK_CYCLES_FOR_15MS + 1);
    localparam int unsigned XFER_W = $clog2(CLOCK_CYCLES_FOR_2MS + 1);

    localparam logic [INIT_W-1:0] INIT_LIMIT = INIT_W'(CLOCK_CYCLES_FOR_101US);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(CLOCK_CYCLES_FOR_15MS);
    localparam logic [XFER_W-1:0] XFER_LIMIT = XFER_W'(CLOCK_CYCLES_FOR_2MS);

    ps2_tx_state_t     state;
    ps2_tx_state_t     next_state;

    logic [8:0]        frame;
    logic [3:0]        bit_index;

    logic [INIT_W-1:0] init_counter;
    logic [WAIT_W-1:0] wait_counter;
    logic [XFER_W-1:0] xfer_counter;

    logic              in_xfer;
    logic              init_done;
    logic              wait_expired;
    logic              xfer_expired;

    logic              clk_oe;
    logic              dat_oe;
    logic              dat_value;

    // Data, stop and acknowledge phases share one overall time budget.
    assign in_xfer      = (state == S_TX_DATA) || (state == S_TX_STOP) ||
                          (state == S_RX_ACK);
    assign init_done    = (init_counter == INIT_LIMIT);
    assign wait_expired = (wait_counter == WAIT_LIMIT);
    assign xfer_expired = (xfer_counter == XFER_LIMIT);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a device clock edge takes precedence over a timeout
    // expiring in the same cycle.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (send_command) begin
                    next_state = S_INIT;
                end
            end
            S_INIT: begin
                if (init_done) begin
                    next_state = S_WAIT_CLK;
                end
            end
            S_WAIT_CLK: begin
                if (ps2_clk_negedge) begin
                    next_state = S_TX_DATA;
                end else if (wait_expired) begin
                    next_state = S_ERROR;
                end
            end
            S_TX_DATA: begin
                if (ps2_clk_negedge) begin
                    if (bit_index == PARITY_BIT_INDEX) begin
                        next_state = S_TX_STOP;
                    end
                end else if (xfer_expired) begin
                    next_state = S_ERROR;
                end
            end
            S_TX_STOP: begin
                if (ps2_clk_negedge) begin
                    next_state = S_RX_ACK;
                end else if (xfer_expired) begin
                    next_state = S_ERROR;
                end
            end
            S_RX_ACK: begin
                if (ps2_clk_posedge) begin
                    next_state = S_SENT;
                end else if (xfer_expired) begin
                    next_state = S_ERROR;
                end
            end
            S_SENT: begin
                if (!send_command) begin
                    next_state = S_IDLE;
                end
            end
            S_ERROR: begin
                if (!send_command) begin
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Frame capture: tracks the command while idle, frozen for the transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame <= '0;
        end else if (state == S_IDLE) begin
            frame <= {odd_parity_bit(the_command), the_command};
        end
    end

    // Bit pointer: advances on each device falling edge while shifting data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_index <= '0;
        end else if (state == S_IDLE) begin
            bit_index <= '0;
        end else if ((state == S_TX_DATA) && ps2_clk_negedge &&
                     (bit_index != PARITY_BIT_INDEX)) begin
            bit_index <= bit_index + 4'd1;
        end
    end

    // Clock-inhibit duration counter, saturating, active only in INIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            init_counter <= '0;
        end else if (state != S_INIT) begin
            init_counter <= '0;
        end else if (!init_done) begin
            init_counter <= init_counter + INIT_W'(1);
        end
    end

    // Device start timeout counter, saturating, active only in WAIT_CLK.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_counter <= '0;
        end else if (state != S_WAIT_CLK) begin
            wait_counter <= '0;
        end else if (!wait_expired) begin
            wait_counter <= wait_counter + WAIT_W'(1);
        end
    end

    // Whole-frame timeout counter; keeps running across all bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xfer_counter <= '0;
        end else if (!in_xfer) begin
            xfer_counter <= '0;
        end else if (!xfer_expired) begin
            xfer_counter <= xfer_counter + XFER_W'(1);
        end
    end

    // Success flag: raised with entry into SENT, held until the request drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            command_was_sent <= 1'b0;
        end else if (next_state == S_SENT) begin
            command_was_sent <= 1'b1;
        end else if (!send_command) begin
            command_was_sent <= 1'b0;
        end
    end

    // Timeout flag: raised with entry into ERROR, held until the request drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            error_communication_timed_out <= 1'b0;
        end else if (next_state == S_ERROR) begin
            error_communication_timed_out <= 1'b1;
        end else if (!send_command) begin
            error_communication_timed_out <= 1'b0;
        end
    end

    // Line drivers: clock pulled low only during the inhibit, data low for the
    // start bit, then the frame bits; the stop bit is the released line.
    always_comb begin
        clk_oe    = 1'b0;
        dat_oe    = 1'b0;
        dat_value = 1'b0;
        case (state)
            S_INIT: begin
                clk_oe = 1'b1;
                dat_oe = 1'b1;
            end
            S_WAIT_CLK: begin
                dat_oe = 1'b1;
            end
            S_TX_DATA: begin
                dat_oe    = 1'b1;
                dat_value = frame[bit_index];
            end
            default: begin
                clk_oe = 1'b0;
            end
        endcase
    end

    assign PS2_CLK = clk_oe ? 1'b0 : 1'bz;
    assign PS2_DAT = dat_oe ? dat_value : 1'bz;

endmodule

// File: tb/tb_altera_up_ps2_command_out.sv
// Self-checking bench for the PS/2 command transmitter, with shortened
// timing limits and a strobe-level device model.
module tb_altera_up_ps2_command_out;

    localparam int unsigned T101 = 20;
    localparam int unsigned T15  = 200;
    localparam int unsigned T2   = 100;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] the_command;
    logic       send_command;
    logic       ps2_clk_posedge;
    logic       ps2_clk_negedge;
    wire        ps2_clk_line;
    wire        ps2_dat_line;
    logic       command_was_sent;
    logic       error_communication_timed_out;

    int         errors = 0;
    int         checks = 0;
    int unsigned cyc   = 0;
    int unsigned t_tx  = 0;

    // Released lines read high through the bus pull-ups.
    pullup (ps2_clk_line);
    pullup (ps2_dat_line);

    altera_up_ps2_command_out #(
        .CLOCK_CYCLES_FOR_101US(T101),
        .CLOCK_CYCLES_FOR_15MS (T15),
        .CLOCK_CYCLES_FOR_2MS  (T2)
    ) dut (
        .clk                          (clk),
        .reset                        (reset),
        .the_command                  (the_command),
        .send_command                 (send_command),
        .ps2_clk_posedge              (ps2_clk_posedge),
        .ps2_clk_negedge              (ps2_clk_negedge),
        .PS2_CLK                      (ps2_clk_line),
        .PS2_DAT                      (ps2_dat_line),
        .command_was_sent             (command_was_sent),
        .error_communication_timed_out(error_communication_timed_out)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference frame: command LSB first, then a bit making the ones count odd.
    function automatic logic [8:0] model_frame(input logic [7:0] cmd);
        logic [8:0] f;
        for (int i = 0; i < 8; i++) f[i] = ((cmd >> i) & 8'd1) != 0;
        f[8] = (($countones(cmd) % 2) == 0);
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) tick();
    endtask

    task automatic pulse_neg();
        ps2_clk_negedge = 1'b1;
        tick();
        ps2_clk_negedge = 1'b0;
    endtask

    task automatic pulse_pos();
        ps2_clk_posedge = 1'b1;
        tick();
        ps2_clk_posedge = 1'b0;
    endtask

    // Raise the request and measure the clock inhibit; ends in WAIT_CLK.
    task automatic start_request(input logic [7:0] cmd);
        int unsigned low_cycles = 0;
        int unsigned guard = 0;
        int unsigned dat_bad = 0;
        the_command  = cmd;
        send_command = 1'b1;
        tick();
        the_command = 8'($urandom);
        while (ps2_clk_line !== 1'b0 && guard < 10) begin tick(); guard++; end
        while (ps2_clk_line === 1'b0 && guard < 1000) begin
            if (ps2_dat_line !== 1'b0) dat_bad++;
            low_cycles++;
            tick();
            guard++;
        end
        check("clk_inhibit_len", 32'(low_cycles), 32'(T101 + 1));
        check("inhibit_dat_low", 32'(dat_bad), 32'd0);
        check("start_bit", 32'(ps2_dat_line), 32'd0);
    endtask

    // Device clocks start bit and data; returns early after stop_after bits.
    task automatic run_frame(input logic [7:0] cmd, input int unsigned stop_after,
                             input bit drop_mid);
        logic [8:0] f;
        f = model_frame(cmd);
        start_request(cmd);
        idle($urandom_range(0, 20));
        check("start_bit_hold", 32'(ps2_dat_line), 32'd0);
        pulse_neg();
        t_tx = cyc;
        for (int i = 0; i < 9; i++) begin
            if (i == stop_after) return;
            idle($urandom_range(0, 3));
            pulse_pos();
            check($sformatf("data_bit%0d_%02h", i, cmd), 32'(ps2_dat_line), 32'(f[i]));
            if (drop_mid && i == 4) send_command = 1'b0;
            pulse_neg();
        end
        pulse_pos();
        idle($urandom_range(0, 3));
        check("stop_released", 32'(ps2_dat_line), 32'd1);
        pulse_neg();
        idle($urandom_range(0, 3));
        check("ack_wait_sent", 32'(command_was_sent), 32'd0);
        check("ack_dat_released", 32'(ps2_dat_line), 32'd1);
        pulse_pos();
        check("sent_set", 32'(command_was_sent), 32'd1);
        check("sent_no_error", 32'(error_communication_timed_out), 32'd0);
    endtask

    task automatic wait_error(output int unsigned waited);
        waited = 0;
        while (error_communication_timed_out !== 1'b1 && waited < 1000) begin
            tick();
            waited++;
        end
    endtask

    task automatic drop_and_check(input string tag);
        send_command = 1'b0;
        tick();
        check({tag, "_sent_clr"}, 32'(command_was_sent), 32'd0);
        check({tag, "_err_clr"}, 32'(error_communication_timed_out), 32'd0);
        tick();
        check({tag, "_lines"}, {30'd0, ps2_clk_line, ps2_dat_line}, 32'd3);
    endtask

    initial begin
        int unsigned waited;
        logic [7:0]  cmd;
        logic [8:0]  f;
        int unsigned held_bad;

        reset = 1'b1;
        send_command = 1'b0;
        ps2_clk_posedge = 1'b0;
        ps2_clk_negedge = 1'b0;
        the_command = 8'h00;
        idle(3);
        check("rst_lines", {30'd0, ps2_clk_line, ps2_dat_line}, 32'd3);
        check("rst_sent", 32'(command_was_sent), 32'd0);
        check("rst_err", 32'(error_communication_timed_out), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        idle(2);

        // Nominal 0xF4, flag held until the request drops.
        run_frame(8'hF4, 9, 1'b0);
        idle(3);
        check("sent_hold", 32'(command_was_sent), 32'd1);
        drop_and_check("f4");

        // Parity corner cases and random commands.
        run_frame(8'h00, 9, 1'b0); drop_and_check("p00");
        run_frame(8'hFF, 9, 1'b0); drop_and_check("pff");
        run_frame(8'h01, 9, 1'b0); drop_and_check("p01");
        repeat (4) begin
            run_frame(8'($urandom), 9, 1'b0);
            drop_and_check("rand");
        end

        // Request withdrawn mid-frame: frame still completes, flag pulses once.
        run_frame(8'($urandom), 9, 1'b1);
        tick();
        check("drop_sent_clr", 32'(command_was_sent), 32'd0);
        check("drop_lines", {30'd0, ps2_clk_line, ps2_dat_line}, 32'd3);

        // No device: start-wait counter runs 0..T15, so WAIT_CLK lasts T15+1 cycles.
        start_request(8'($urandom));
        wait_error(waited);
        check("nodev_err_time", 32'(waited), 32'(T15 + 1));
        check("nodev_lines", {30'd0, ps2_clk_line, ps2_dat_line}, 32'd3);
        check("nodev_sent", 32'(command_was_sent), 32'd0);
        drop_and_check("nodev");

        // Stalled device after four data bits: whole-frame budget T2+1 cycles.
        run_frame(8'($urandom), 4, 1'b0);
        wait_error(waited);
        check("stall_err_time", 32'(cyc - t_tx), 32'(T2 + 1));
        check("stall_lines", {30'd0, ps2_clk_line, ps2_dat_line}, 32'd3);
        drop_and_check("stall");

        // Device edge arriving in the same cycle the start wait expires wins.
        cmd = 8'($urandom);
        f = model_frame(cmd);
        start_request(cmd);
        idle(T15);
        check("edge_race_dat", 32'(ps2_dat_line), 32'd0);
        pulse_neg();
        t_tx = cyc;
        check("edge_beats_timeout", 32'(error_communication_timed_out), 32'd0);
        check("edge_race_bit0", 32'(ps2_dat_line), 32'(f[0]));
        wait_error(waited);
        check("race_stall_time", 32'(cyc - t_tx), 32'(T2 + 1));
        drop_and_check("race");

        // Asynchronous reset in the middle of the data bits.
        start_request(8'h00);
        pulse_neg();
        idle(2);
        pulse_neg();
        check("pre_reset_dat", 32'(ps2_dat_line), 32'd0);
        #3;
        reset = 1'b1;
        #1;
        check("mid_reset_lines", {30'd0, ps2_clk_line, ps2_dat_line}, 32'd3);
        check("mid_reset_flags", {30'd0, command_was_sent, error_communication_timed_out}, 32'd0);
        #1;
        reset = 1'b0;
        send_command = 1'b0;
        idle(2);
        run_frame(8'($urandom), 9, 1'b0);
        drop_and_check("post_reset");

        // Request held after success: no retransmission.
        run_frame(8'($urandom), 9, 1'b0);
        held_bad = 0;
        repeat (40) begin
            tick();
            if (command_was_sent !== 1'b1 || ps2_clk_line !== 1'b1 || ps2_dat_line !== 1'b1)
                held_bad++;
        end
        check("held_no_resend", 32'(held_bad), 32'd0);
        check("held_sent", 32'(command_was_sent), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        check("reset_clears_sent", 32'(command_was_sent), 32'd0);
        #1;
        reset = 1'b0;
        send_command = 1'b0;
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
